seg_display: RTL
================

# seg_display

Four-digit multiplexed 7-segment driver that shows the signal-generator settings produced by the key-control block. It displays the waveform index, frequency index and phase index. It blinks whichever field (frequency or phase) is currently selected for editing. The block sits between the key-control outputs and the board's common-anode display pins, at a 50 MHz system clock.

## Interface

- SCAN_DIV, 50_000: clock cycles each digit stays enabled (1 ms at 50 MHz); must be ≥2.
- BLINK_DIV, 12_500_000: clock cycles per blink half-period (250 ms, 2 Hz blink); must be ≥2.
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- wave_type_in  input  3  waveform index; valid range 0–4.
- f_p_choose_in  input  1  edit selection: 0 = frequency field, 1 = phase field.
- f_count_in  input  4  frequency index; valid range 0–11.
- p_count_in  input  2  phase index, 0–3.
- seg_out  output  8  segment drive, active low; bit7 = dp, bits6:0 = g..a.
- dig_out  output  4  digit enables, active low; dig_out[0] is the rightmost digit.

## Operation

**Digit map**
- Digit 3 shows the wave index.
- Digit 2 shows the frequency tens digit; digit 1 shows the frequency units digit.
- Digit 0 shows the phase index.

**Shadow registers**
- wave, freq, phase and choose are held in shadow registers.
- All four load together from the inputs only on the clock edge where the digit index wraps 3→0.
- This prevents a torn frame; between loads, input changes are ignored.
- Reset value of every shadow register is 0.

**Scan counter**
- Counts 0..SCAN_DIV-1.
- At its terminal count the digit index (2 bits) increments, wrapping 3→0.

**Blink**
- A blink counter counts 0..BLINK_DIV-1 and toggles blink_on at its terminal count.
- blink_on resets to 1 (visible).
- When blink_on = 0, the selected field outputs blank while its digit enable stays active.
  - choose = 0: digits 2 and 1 blank.
  - choose = 1: digit 0 blanks.

**Digit values**
- Frequency value 0–11: tens digit = 0 or 1, units digit = value mod 10.
- Frequency value 12–15: both frequency digits show '-'.
- Wave value 5–7: digit 3 shows '-'.
- Phase: always shown as 0–3.

**Segment codes** (dp is always off, so bit7 = 1)
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- '-' = BF, blank = FF.

**Outputs**
- dig_out has exactly one bit low, the bit matching the registered digit index; no two digits are ever enabled together.
- seg_out and dig_out are registered.

## Timing

**Reset**
- Reset asserted: seg_out = 8'hFF, dig_out = 4'b1111.
- Scan counter = 0, blink counter = 0, digit index = 0, blink_on = 1, shadows = 0.

**Output latency**
- seg_out/dig_out are computed from the current digit index, shadows and blink_on.
- They update one clock after those registers change.
- First edge after reset release: dig_out = 4'b1110, seg_out = C0 (phase 0).

**Per-digit and per-frame timing**
- Each digit is enabled for exactly SCAN_DIV cycles.
- A full frame lasts 4×SCAN_DIV cycles.

**Input update latency**
- A new input value appears on digit 0 one cycle after the next 3→0 wrap.
- Worst-case latency is 4×SCAN_DIV+1 cycles.

**Simultaneous events**
- Blink toggle coinciding with a digit change: both take effect on the same edge; the digit's first output cycle already reflects the new blink_on.
- Shadow load coinciding with a blink toggle: both apply on the same edge.

**Reset mid-operation**
- Outputs go to FF/1111 immediately (asynchronously).
- Scanning restarts at digit 0 with zero shadows.
- Scanning does not resume from the interrupted digit.

## Test plan

Bench parameters: SCAN_DIV = 4, BLINK_DIV = 64.

1. **Reset and first digit.** Hold rst_n = 0 → seg_out = FF, dig_out = 1111. Release → next edge dig_out = 1110, seg_out = C0. dig_out then steps 1101, 1011, 0111 every 4 cycles and returns to 1110.
2. **Normal values.** Inputs wave = 3, f = 11, p = 2, choose = 1, applied before a frame wrap. Over the first 32 cycles after the wrap, blink_on = 1 throughout → following frame shows digit3 = B0, digit2 = F9, digit1 = F9, digit0 = A4.
3. **Out-of-range values.** wave = 6, f = 13 → digit3 = BF, digits 2 and 1 = BF. Phase digit is unaffected.
4. **No mid-frame update.** Change f from 2 to 7 while digit 1 is enabled → rest of the current frame still shows A4 on digit 1. The next frame shows F8.
5. **Blink.** choose = 0, f = 5. After 64 cycles → digits 2 and 1 output FF with enables still active, while digits 3 and 0 are unchanged. After 64 more cycles the frequency digits reappear. Switch to choose = 1 → only digit 0 blinks.
6. **Reset mid-scan.** Pulse rst_n low for a few cycles while digit 2 is enabled → immediate FF/1111. After release → scan restarts at digit 0 with value C0 and blink_on = 1.

Source files
------------

// File: rtl/seg_display.sv
// Four-digit multiplexed common-anode 7-segment driver for the signal-generator
// settings: wave (digit 3), frequency tens/units (digits 2/1), phase (digit 0).
module seg_display #(
  parameter int SCAN_DIV  = 50_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] wave_type_in,
  input  logic       f_p_choose_in,
  input  logic [3:0] f_count_in,
  input  logic [1:0] p_count_in,
  output logic [7:0] seg_out,
  output logic [3:0] dig_out
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic [SW-1:0] scan_cnt,  scan_cnt_next;
  logic [BW-1:0] blink_cnt, blink_cnt_next;
  logic [1:0]    digit_idx, digit_idx_next;
  logic          blink_on,  blink_on_next;

  logic [2:0]    wave_q;
  logic [3:0]    freq_q;
  logic [1:0]    phase_q;
  logic          choose_q;

  logic          scan_tc;
  logic          blink_tc;
  logic          frame_wrap;

  logic          freq_ok;
  logic          freq_tens;
  logic [3:0]    freq_units;
  logic [7:0]    seg_next;
  logic [3:0]    dig_next;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Timebase: scan and blink counters free-run from reset, digit index steps at scan terminal count.
  always_comb begin
    scan_tc        = (scan_cnt == SCAN_LAST);
    blink_tc       = (blink_cnt == BLINK_LAST);
    frame_wrap     = scan_tc && (digit_idx == 2'd3);
    scan_cnt_next  = scan_tc ? '0 : scan_cnt + 1'b1;
    blink_cnt_next = blink_tc ? '0 : blink_cnt + 1'b1;
    digit_idx_next = scan_tc ? digit_idx + 2'd1 : digit_idx;
    blink_on_next  = blink_tc ? ~blink_on : blink_on;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      blink_cnt <= '0;
      digit_idx <= 2'd0;
      blink_on  <= 1'b1;
    end else begin
      scan_cnt  <= scan_cnt_next;
      blink_cnt <= blink_cnt_next;
      digit_idx <= digit_idx_next;
      blink_on  <= blink_on_next;
    end
  end

  // Shadows capture all inputs together at the 3->0 wrap so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_q   <= 3'd0;
      freq_q   <= 4'd0;
      phase_q  <= 2'd0;
      choose_q <= 1'b0;
    end else if (frame_wrap) begin
      wave_q   <= wave_type_in;
      freq_q   <= f_count_in;
      phase_q  <= p_count_in;
      choose_q <= f_p_choose_in;
    end
  end

  always_comb begin
    freq_ok    = (freq_q <= 4'd11);
    freq_tens  = (freq_q >= 4'd10);
    freq_units = freq_tens ? (freq_q - 4'd10) : freq_q;
    seg_next   = SEG_BLANK;
    dig_next   = ~(4'b0001 << digit_idx);
    case (digit_idx)
      2'd3: seg_next = (wave_q <= 3'd4) ? seg7({1'b0, wave_q}) : SEG_DASH;
      2'd2: begin
        if (!blink_on && !choose_q) seg_next = SEG_BLANK;
        else if (freq_ok)           seg_next = seg7({3'b000, freq_tens});
        else                        seg_next = SEG_DASH;
      end
      2'd1: begin
        if (!blink_on && !choose_q) seg_next = SEG_BLANK;
        else if (freq_ok)           seg_next = seg7(freq_units);
        else                        seg_next = SEG_DASH;
      end
      default: begin
        if (!blink_on && choose_q)  seg_next = SEG_BLANK;
        else                        seg_next = seg7({2'b00, phase_q});
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= SEG_BLANK;
      dig_out <= 4'b1111;
    end else begin
      seg_out <= seg_next;
      dig_out <= dig_next;
    end
  end

endmodule
